// File: rtl/esfa_host_sequencer_if.sv
// Host request/response channel plus the ESFA array command/result bus.
// master = host + array side, slave = the sequencer.
interface esfa_host_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_index;
    logic [7:0] req_value;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_op;
    logic       rsp_found;
    logic [7:0] rsp_value;
    logic       rsp_err;
    logic       init_done;
    logic [7:0] new_index;
    logic [7:0] new_value;
    logic [7:0] metadata;
    logic       isMetadata;
    logic [7:0] selector;
    logic       resultBool;
    logic [7:0] resultValue;

    modport master (
        output req_valid, req_op, req_index, req_value, rsp_ready, resultBool, resultValue,
        input  req_ready, rsp_valid, rsp_op, rsp_found, rsp_value, rsp_err, init_done,
               new_index, new_value, metadata, isMetadata, selector
    );

    modport slave (
        input  req_valid, req_op, req_index, req_value, rsp_ready, resultBool, resultValue,
        output req_ready, rsp_valid, rsp_op, rsp_found, rsp_value, rsp_err, init_done,
               new_index, new_value, metadata, isMetadata, selector
    );
endinterface

// File: rtl/esfa_host_sequencer.sv
// Single-outstanding host request sequencer that drives the ESFA array command
// bus and returns query results sampled a fixed latency after launch.
module esfa_host_sequencer #(
    parameter logic [7:0] SEL_IDLE   = 8'h00,
    parameter logic [7:0] SEL_WRITE  = 8'h01,
    parameter logic [7:0] SEL_QUERY  = 8'h02,
    parameter int         RESULT_LAT = 2,
    parameter int         CELLS      = 8
) (
    input logic                  clk,
    input logic                  reset_n,
    esfa_host_sequencer_if.slave bus
);
    typedef enum logic [1:0] {INIT, IDLE, HOLD, RESP} state_t;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_META  = 2'd1;
    localparam logic [1:0] OP_QUERY = 2'd2;
    localparam logic [1:0] OP_NOP   = 2'd3;
    localparam logic [3:0] LAT      = 4'(RESULT_LAT);

    state_t     state;
    logic [1:0] init_cnt;
    logic [3:0] wait_cnt;
    logic [1:0] op_q;
    logic       err_q;

    logic       req_ready;
    logic       rsp_valid;
    logic [1:0] rsp_op;
    logic       rsp_found;
    logic [7:0] rsp_value;
    logic       rsp_err;
    logic       init_done;
    logic [7:0] new_index;
    logic [7:0] new_value;
    logic [7:0] metadata;
    logic       is_meta;
    logic [7:0] selector;

    logic idx_bad;
    assign idx_bad = 32'(bus.req_index) >= CELLS;

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_op     = rsp_op;
    assign bus.rsp_found  = rsp_found;
    assign bus.rsp_value  = rsp_value;
    assign bus.rsp_err    = rsp_err;
    assign bus.init_done  = init_done;
    assign bus.new_index  = new_index;
    assign bus.new_value  = new_value;
    assign bus.metadata   = metadata;
    assign bus.isMetadata = is_meta;
    assign bus.selector   = selector;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            init_cnt  <= '0;
            wait_cnt  <= '0;
            op_q      <= '0;
            err_q     <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_op    <= '0;
            rsp_found <= 1'b0;
            rsp_value <= '0;
            rsp_err   <= 1'b0;
            init_done <= 1'b0;
            new_index <= '0;
            new_value <= '0;
            metadata  <= '0;
            is_meta   <= 1'b0;
            selector  <= SEL_IDLE;
        end else begin
            case (state)
                INIT: begin
                    // Array must show two consecutive all-zero results after its startup clear.
                    if (!bus.resultBool && bus.resultValue == 8'h00) begin
                        init_cnt <= init_cnt + 2'd1;
                        if (init_cnt == 2'd1) begin
                            state     <= IDLE;
                            init_done <= 1'b1;
                            req_ready <= 1'b1;
                        end
                    end else begin
                        init_cnt <= '0;
                    end
                end

                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready <= 1'b0;
                        op_q      <= bus.req_op;
                        err_q     <= (bus.req_op != OP_NOP) && idx_bad;
                        state     <= RESP;
                        if (bus.req_op != OP_NOP && !idx_bad) begin
                            new_index <= bus.req_index;
                            case (bus.req_op)
                                OP_WRITE: begin
                                    selector  <= SEL_WRITE;
                                    new_value <= bus.req_value;
                                end
                                OP_META: begin
                                    selector <= SEL_WRITE;
                                    metadata <= bus.req_value;
                                    is_meta  <= 1'b1;
                                end
                                default: begin
                                    selector <= SEL_QUERY;
                                    wait_cnt <= LAT;
                                    state    <= HOLD;
                                end
                            endcase
                        end
                    end
                end

                HOLD: begin
                    if (wait_cnt == 4'd1) begin
                        rsp_found <= bus.resultBool;
                        rsp_value <= bus.resultValue;
                        rsp_op    <= op_q;
                        rsp_valid <= 1'b1;
                        selector  <= SEL_IDLE;
                        new_index <= '0;
                        state     <= RESP;
                    end
                    wait_cnt <= wait_cnt - 4'd1;
                end

                RESP: begin
                    // Non-query ops arrive here with rsp_valid low: one command cycle, then respond.
                    if (!rsp_valid) begin
                        selector  <= SEL_IDLE;
                        new_index <= '0;
                        new_value <= '0;
                        metadata  <= '0;
                        is_meta   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_op    <= op_q;
                        rsp_err   <= err_q;
                    end else if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_op    <= '0;
                        rsp_found <= 1'b0;
                        rsp_value <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_esfa_host_sequencer.sv
// Table-driven and random request stimulus with a response scoreboard and a
// small behavioural array answering queries from the DUT command bus.
module tb_esfa_host_sequencer;
    localparam int LAT   = 2;
    localparam int CELLS = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    esfa_host_sequencer_if bus();

    esfa_host_sequencer #(.RESULT_LAT(LAT), .CELLS(CELLS)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct {
        logic [1:0] op; logic [7:0] idx; logic [7:0] val; int hold;
        logic [7:0] e_sel; logic [7:0] e_idx; logic [7:0] e_nval; logic [7:0] e_meta;
        logic e_ism; logic e_err;
    } vec_t;

    typedef struct {
        logic [1:0] op; logic found; logic [7:0] value; logic err;
    } rsp_t;

    rsp_t sb[$];
    rsp_t mon_e;
    int total = 0;
    int passed = 0;

    // Behavioural array: written from the DUT command bus, answers queries combinationally.
    logic       a_hit  [CELLS] = '{default: 1'b0};
    logic [7:0] a_val  [CELLS] = '{default: 8'h00};
    logic [7:0] a_meta [CELLS] = '{default: 8'h00};
    logic       force_en = 1'b1;
    logic       fb = 1'b0;
    logic [7:0] fv = 8'h00;
    logic       q_hit;
    logic [7:0] q_val;

    always_comb begin
        q_hit = 1'b0;
        q_val = 8'h00;
        if (bus.selector == 8'h02 && bus.new_index < 8'(CELLS)) begin
            q_hit = a_hit[bus.new_index[2:0]];
            q_val = a_val[bus.new_index[2:0]] ^ a_meta[bus.new_index[2:0]];
        end
    end
    assign bus.resultBool  = force_en ? fb : q_hit;
    assign bus.resultValue = force_en ? fv : q_val;

    always @(posedge clk) begin
        if (bus.selector == 8'h01 && bus.new_index < 8'(CELLS)) begin
            if (bus.isMetadata) a_meta[bus.new_index[2:0]] <= bus.metadata;
            else begin
                a_val[bus.new_index[2:0]] <= bus.new_value;
                a_hit[bus.new_index[2:0]] <= 1'b1;
            end
        end
    end

    // Reference model of array contents, updated from requests as they are issued.
    logic       m_hit  [CELLS] = '{default: 1'b0};
    logic [7:0] m_val  [CELLS] = '{default: 8'h00};
    logic [7:0] m_meta [CELLS] = '{default: 8'h00};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_op",    32'(bus.rsp_op),    32'(mon_e.op));
                chk("rsp_found", 32'(bus.rsp_found), 32'(mon_e.found));
                chk("rsp_value", 32'(bus.rsp_value), 32'(mon_e.value));
                chk("rsp_err",   32'(bus.rsp_err),   32'(mon_e.err));
            end
        end
    end

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] idx, input logic [7:0] val);
        vec_t v;
        logic bad;
        bad = idx >= 8'(CELLS);
        v = '{op: op, idx: idx, val: val, hold: 0, e_sel: 8'h00, e_idx: 8'h00,
              e_nval: 8'h00, e_meta: 8'h00, e_ism: 1'b0, e_err: (op != 2'd3) && bad};
        if (op != 2'd3 && !bad) begin
            v.e_idx = idx;
            case (op)
                2'd0: begin v.e_sel = 8'h01; v.e_nval = val; end
                2'd1: begin v.e_sel = 8'h01; v.e_meta = val; v.e_ism = 1'b1; end
                default: v.e_sel = 8'h02;
            endcase
        end
        return v;
    endfunction

    task automatic do_req(input vec_t v);
        rsp_t e;
        int n;
        int lat;
        logic in_rng;
        in_rng = v.idx < 8'(CELLS);
        e.op = v.op; e.err = v.e_err; e.found = 1'b0; e.value = 8'h00;
        if (v.op == 2'd2 && in_rng) begin
            e.found = m_hit[v.idx[2:0]];
            e.value = m_val[v.idx[2:0]] ^ m_meta[v.idx[2:0]];
        end
        if (in_rng && v.op == 2'd0) begin m_val[v.idx[2:0]] = v.val; m_hit[v.idx[2:0]] = 1'b1; end
        if (in_rng && v.op == 2'd1) m_meta[v.idx[2:0]] = v.val;
        lat = (v.op == 2'd2 && in_rng) ? LAT : 1;

        n = 0;
        while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.rsp_ready = (v.hold == 0);
        bus.req_valid = 1'b1; bus.req_op = v.op; bus.req_index = v.idx; bus.req_value = v.val;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op = 2'($urandom); bus.req_index = 8'($urandom); bus.req_value = 8'($urandom);
        sb.push_back(e);
        chk("cmd_selector",  32'(bus.selector),   32'(v.e_sel));
        chk("cmd_new_index", 32'(bus.new_index),  32'(v.e_idx));
        chk("cmd_new_value", 32'(bus.new_value),  32'(v.e_nval));
        chk("cmd_metadata",  32'(bus.metadata),   32'(v.e_meta));
        chk("cmd_isMeta",    32'(bus.isMetadata), 32'(v.e_ism));
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);

        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (!bus.rsp_valid && n < 40) chk("cmd_hold_selector", 32'(bus.selector), 32'(v.e_sel));
        end while (!bus.rsp_valid && n < 40);
        chk("rsp_latency", 32'(n), 32'(lat));
        chk("bus_idle_at_rsp", 32'(bus.selector), 32'd0);

        for (int k = 0; k < v.hold; k++) begin
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_found", 32'(bus.rsp_found), 32'(e.found));
            chk("bp_value", 32'(bus.rsp_value), 32'(e.value));
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        if (v.hold > 0) begin @(posedge clk); #1; end
        else begin @(posedge clk); #1; end
        chk("rsp_cleared", 32'(bus.rsp_valid), 32'd0);
        chk("ready_after_hs", 32'(bus.req_ready), 32'd1);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{2'd0, 8'h03, 8'hA5, 0, 8'h01, 8'h03, 8'hA5, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{2'd2, 8'h03, 8'h00, 4, 8'h02, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{2'd1, 8'h02, 8'h7E, 0, 8'h01, 8'h02, 8'h00, 8'h7E, 1'b1, 1'b0};
        tbl[3] = '{2'd0, 8'h09, 8'h33, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[4] = '{2'd3, 8'h05, 8'h44, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{2'd2, 8'h02, 8'h00, 1, 8'h02, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{2'd2, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[7] = '{2'd0, 8'h07, 8'h3C, 0, 8'h01, 8'h07, 8'h3C, 8'h00, 1'b0, 1'b0};
        tbl[8] = '{2'd2, 8'h07, 8'h00, 0, 8'h02, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[9] = '{2'd3, 8'hC8, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

        bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_index = 8'h00; bus.req_value = 8'h00;
        bus.rsp_ready = 1'b1;
        fb = 1'b1; fv = 8'h05;
        #12;
        chk("reset_selector",  32'(bus.selector),  32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_init_done", 32'(bus.init_done), 32'd0);
        chk("reset_rsp_err",   32'(bus.rsp_err),   32'd0);

        // Startup: nonzero result for 3 edges, then 0/0 must take exactly 2 edges.
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("init_busy_done", 32'(bus.init_done), 32'd0);
            chk("init_busy_ready", 32'(bus.req_ready), 32'd0);
        end
        fb = 1'b0; fv = 8'h00;
        @(posedge clk); #1;
        chk("init_edge1_done", 32'(bus.init_done), 32'd0);
        chk("init_edge1_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("init_edge2_done", 32'(bus.init_done), 32'd1);
        chk("init_edge2_ready", 32'(bus.req_ready), 32'd1);
        force_en = 1'b0;

        foreach (tbl[i]) do_req(tbl[i]);

        // Reset asserted in the middle of a query hold.
        bus.req_valid = 1'b1; bus.req_op = 2'd2; bus.req_index = 8'h03;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("mid_q_selector", 32'(bus.selector), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_selector",  32'(bus.selector),  32'd0);
        chk("async_rst_new_index", 32'(bus.new_index), 32'd0);
        chk("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("async_rst_init_done", 32'(bus.init_done), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("reinit_edge1", 32'(bus.init_done), 32'd0);
        @(posedge clk); #1;
        chk("reinit_edge2", 32'(bus.init_done), 32'd1);

        for (int i = 0; i < 20; i++)
            do_req(mk(2'($urandom_range(0, 3)), 8'($urandom_range(0, 9)), 8'($urandom)));

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
